composite_ecc_encoder: RTL and testbench
========================================

COMPOSITE_ECC_ENCODER -- requirements
Module: composite_ecc_encoder

Interface
REQ-001 Parameter DEPTH, default 4, output FIFO depth in codewords; legal values 2, 4, 8, 16.
REQ-002 clk  input  1  rising-edge clock; one clock domain only.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  upstream offers in_data this cycle.
REQ-005 in_ready  output  1  block accepts in_data this cycle.
REQ-006 in_data  input  8  raw data byte, bits d7..d0.
REQ-007 out_valid  output  1  out_codeword holds a valid codeword.
REQ-008 out_ready  input  1  downstream consumes out_codeword this cycle.
REQ-009 out_codeword  output  13  encoded word: {par, d7 d6 d5 d4 p3 d3 d2 d1 p2 d0 p1 p0}.
REQ-010 level  output  5  current FIFO occupancy, 0..DEPTH.
REQ-011 enc_count  output  16  number of codewords delivered downstream.

Function
REQ-012 Accept occurs when in_valid && in_ready; deliver occurs when out_valid && out_ready.
REQ-013 p0=d0^d1^d3^d4^d6; p1=d0^d2^d3^d5^d6; p2=d1^d2^d3^d7; p3=d4^d5^d6^d7.
REQ-014 par = XNOR-reduction of d7..d0 (odd parity over the data byte).
REQ-015 The codeword is computed from in_data at accept and written into the FIFO tail in the same clock edge.
REQ-016 Latency: with the FIFO empty, a word accepted at edge N is presented with out_valid=1 immediately after edge N, so it is deliverable in cycle N+1.
REQ-017 out_valid = (level != 0); out_codeword = FIFO head, held stable while out_valid && !out_ready.
REQ-018 in_ready = !rst && (level < DEPTH), computed from registered level only; a same-cycle deliver does not raise in_ready when full.
REQ-019 Accept and deliver in the same cycle leave level unchanged and preserve FIFO order.
REQ-020 Empty: out_valid=0, out_ready is ignored, and level does not underflow.
REQ-021 Full: in_ready=0, in_valid is ignored, and no entry is overwritten.
REQ-022 Read and write pointers wrap modulo DEPTH.
REQ-023 enc_count increments by 1 per deliver and wraps from 0xFFFF to 0x0000.
REQ-024 in_data is ignored when no accept occurs; the block holds no other state.

Reset
REQ-025 While rst=1: in_ready=0, out_valid=0, out_codeword=0, level=0, enc_count=0, and both pointers=0.
REQ-026 Reset mid-transfer discards all buffered codewords with no partial deliver; in_ready=1 in the first cycle after rst falls.

Configuration
REQ-027 Macro COMPOSITE_ECC_ENC_INJECT_EN, when defined, adds input inject_en (1) and input inject_pos (4), sampled at accept.
REQ-028 With the macro defined and inject_en=1 at accept, the stored codeword has bit inject_pos inverted; inject_pos values 13..15 inject nothing.
REQ-029 Without the macro, neither port exists and codewords are always clean encodings.

Verification
REQ-030 Reset, then in_data=8'hA5 accepted with out_ready=1 -> next cycle out_valid=1, out_codeword=13'h1A27, and enc_count=1 after the deliver.
REQ-031 Back-to-back 8'h3C, 8'h00, 8'hFF with out_ready=1 -> out_codeword sequence 13'h1362, 13'h1000, 13'h1F77 on consecutive cycles, level never exceeding 1.
REQ-032 out_ready=0 with DEPTH=4 and in_valid held high -> exactly 4 accepts, then in_ready=0 and level=4; releasing out_ready drains the words in order with no loss.
REQ-033 Full FIFO with simultaneous deliver -> in_ready stays 0 that cycle and level goes 4->3.
REQ-034 rst asserted with level=3 -> out_valid=0 and level=0 the next cycle, and no stale codeword appears afterward.
REQ-035 With COMPOSITE_ECC_ENC_INJECT_EN defined: 8'hA5 with inject_en=1, inject_pos=0 -> out_codeword=13'h1A26; with inject_pos=14 -> out_codeword=13'h1A27.

Source files
------------

// File: rtl/composite_ecc_encoder.sv
// Byte-to-13-bit SEC-DED-style encoder feeding a DEPTH-entry codeword FIFO (optional COMPOSITE_ECC_ENC_INJECT_EN error injection).
// Latency: a word accepted into an empty FIFO is presented on out_codeword right after the accepting edge.
// Backpressure: in_ready drops when the registered level reaches DEPTH; out_ready stalls the head in place.
module composite_ecc_encoder #(
    parameter int DEPTH = 4
) (
`ifdef COMPOSITE_ECC_ENC_INJECT_EN
    input  logic        inject_en,
    input  logic [3:0]  inject_pos,
`endif
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:0] out_codeword,
    output logic [4:0]  level,
    output logic [15:0] enc_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [12:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [4:0]    level_q;
    logic [15:0]   count_q;
    logic          accept;
    logic          deliver;
    logic [12:0]   enc_word;
    logic [12:0]   inj_mask;

    function automatic logic [12:0] encode(input logic [7:0] d);
        logic p0, p1, p2, p3, par;
        p0  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        p1  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        p2  = d[1] ^ d[2] ^ d[3] ^ d[7];
        p3  = d[4] ^ d[5] ^ d[6] ^ d[7];
        par = ~^d;
        return {par, d[7], d[6], d[5], d[4], p3, d[3], d[2], d[1], p2, d[0], p1, p0};
    endfunction

`ifdef COMPOSITE_ECC_ENC_INJECT_EN
    // Positions 13..15 fall off the top of the word and inject nothing.
    always_comb begin
        inj_mask = '0;
        if (inject_en && (inject_pos < 4'd13))
            inj_mask = 13'd1 << inject_pos;
    end
`else
    assign inj_mask = '0;
`endif

    assign enc_word     = encode(in_data) ^ inj_mask;
    assign in_ready     = !rst && (level_q < 5'(DEPTH));
    assign out_valid    = !rst && (level_q != 5'd0);
    assign out_codeword = out_valid ? mem[rd_ptr] : '0;
    assign level        = level_q;
    assign enc_count    = count_q;
    assign accept       = in_valid && in_ready;
    assign deliver      = out_valid && out_ready;

    // Storage needs no reset: the head is only visible while level is non-zero.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= enc_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            count_q <= '0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (deliver) begin
                rd_ptr  <= rd_ptr + 1'b1;
                count_q <= count_q + 16'd1;
            end
            case ({accept, deliver})
                2'b10:   level_q <= level_q + 5'd1;
                2'b01:   level_q <= level_q - 5'd1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: tb/tb_composite_ecc_encoder.sv
// Directed plus random bench for composite_ecc_encoder against a queue-based reference model.
module tb_composite_ecc_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_codeword;
    logic [4:0]  level;
    logic [15:0] enc_count;
    logic        inject_en;
    logic [3:0]  inject_pos;

    int errors = 0;
    int checks = 0;

    logic [12:0] q[$];
    logic [15:0] cnt;
    int          dut_max;

    always #5 clk = ~clk;

    composite_ecc_encoder #(.DEPTH(DEPTH)) dut (
`ifdef COMPOSITE_ECC_ENC_INJECT_EN
        .inject_en    (inject_en),
        .inject_pos   (inject_pos),
`endif
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_codeword (out_codeword),
        .level        (level),
        .enc_count    (enc_count)
    );

    // Parity groups expressed as data-byte masks.
    function automatic logic [12:0] ref_code(input logic [7:0] d, input logic ie, input logic [3:0] ip);
        logic [3:0]  p;
        logic [12:0] w;
        p[0] = ^(d & 8'h5B);
        p[1] = ^(d & 8'h6D);
        p[2] = ^(d & 8'h8E);
        p[3] = ^(d & 8'hF0);
        w = {~^d, d[7:4], p[3], d[3:1], p[2], d[0], p[1], p[0]};
`ifdef COMPOSITE_ECC_ENC_INJECT_EN
        if (ie && ip < 13)
            w[ip] = ~w[ip];
`endif
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic [7:0] d,
                         input logic rdy, input logic ie, input logic [3:0] ip);
        logic exp_rdy, exp_vld, acc, del;
        rst        = r;
        in_valid   = v;
        in_data    = d;
        out_ready  = rdy;
        inject_en  = ie;
        inject_pos = ip;
        #1;
        exp_rdy = !r && (q.size() < DEPTH);
        exp_vld = !r && (q.size() != 0);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(exp_vld));
        chk("level", 32'(level), 32'(q.size()));
        chk("enc_count", 32'(enc_count), 32'(cnt));
        if (exp_vld)
            chk("out_codeword", 32'(out_codeword), 32'(q[0]));
        else if (r)
            chk("rst_codeword", 32'(out_codeword), 32'd0);
        acc = v && exp_rdy;
        del = exp_vld && rdy;
        @(posedge clk);
        if (r) begin
            q.delete();
            cnt = '0;
        end else begin
            if (del) begin
                void'(q.pop_front());
                cnt = cnt + 16'd1;
            end
            if (acc)
                q.push_back(ref_code(d, ie, ip));
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        inject_en = 1'b0; inject_pos = '0;
        cnt = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        cycle(1, 1, 8'h55, 1, 0, 0);
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_count", 32'(enc_count), 32'd0);

        // Single word A5
        cycle(0, 1, 8'hA5, 1, 0, 0);
        chk("a5_valid", 32'(out_valid), 32'd1);
        chk("a5_code", 32'(out_codeword), 32'h1A27);
        cycle(0, 0, 8'h00, 1, 0, 0);
        chk("a5_count", 32'(enc_count), 32'd1);

        // Back-to-back stream with out_ready high
        dut_max = 0;
        cycle(0, 1, 8'h3C, 1, 0, 0);
        chk("b2b_3c", 32'(out_codeword), 32'h1362);
        if (int'(level) > dut_max) dut_max = int'(level);
        cycle(0, 1, 8'h00, 1, 0, 0);
        chk("b2b_00", 32'(out_codeword), 32'h1000);
        if (int'(level) > dut_max) dut_max = int'(level);
        cycle(0, 1, 8'hFF, 1, 0, 0);
        chk("b2b_ff", 32'(out_codeword), 32'h1F77);
        if (int'(level) > dut_max) dut_max = int'(level);
        cycle(0, 0, 8'h00, 1, 0, 0);
        chk("b2b_level_max", 32'(dut_max), 32'd1);

        // Fill with out_ready low
        repeat (6) cycle(0, 1, 8'($urandom), 0, 0, 0);
        chk("full_level", 32'(level), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);

        // Full with simultaneous deliver
        cycle(0, 1, 8'h77, 1, 0, 0);
        chk("full_deliver_level", 32'(level), 32'd3);
        repeat (4) cycle(0, 0, 8'h00, 1, 0, 0);
        chk("drained", 32'(level), 32'd0);

        // Reset with three words buffered
        repeat (3) cycle(0, 1, 8'($urandom), 0, 0, 0);
        chk("pre_rst_level", 32'(level), 32'd3);
        cycle(1, 1, 8'h12, 1, 0, 0);
        chk("post_rst_level", 32'(level), 32'd0);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        cycle(0, 0, 8'h00, 1, 0, 0);
        cycle(0, 0, 8'h00, 1, 0, 0);

`ifdef COMPOSITE_ECC_ENC_INJECT_EN
        cycle(0, 1, 8'hA5, 1, 1, 4'd0);
        chk("inject_pos0", 32'(out_codeword), 32'h1A26);
        cycle(0, 1, 8'hA5, 1, 1, 4'd14);
        chk("inject_pos14", 32'(out_codeword), 32'h1A27);
        cycle(0, 0, 8'h00, 1, 0, 0);
`endif

        // Random traffic, with occasional reset
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0), 1'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom));
        end
        repeat (DEPTH + 1) cycle(0, 0, 8'h00, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
